// File: rtl/triangle_scan_pkg.sv
// triangle_scan_pkg: shared coordinate width, FSM states and screen defaults
package triangle_scan_pkg;
    localparam int COORD_W = 12;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    typedef enum logic [1:0] {IDLE, BBOX, SCAN} state_t;
endpackage

// File: rtl/minmax3.sv
// minmax3: combinational signed minimum and maximum of three coordinates
module minmax3
    import triangle_scan_pkg::*;
(
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    input  logic signed [COORD_W-1:0] c,
    output logic signed [COORD_W-1:0] mn,
    output logic signed [COORD_W-1:0] mx
);
    logic signed [COORD_W-1:0] ab_mn, ab_mx;
    always_comb begin
        ab_mn = (a < b) ? a : b;
        ab_mx = (a > b) ? a : b;
        mn = (c < ab_mn) ? c : ab_mn;
        mx = (c > ab_mx) ? c : ab_mx;
    end
endmodule

// File: rtl/triangle_scan.sv
// triangle_scan: latches a triangle, clamps its bounding box to the screen and
// streams every pixel of that box row-major to a point-in-triangle stage
module triangle_scan
    import triangle_scan_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v2y,
    input  logic [COORD_W-1:0] v3x,
    input  logic [COORD_W-1:0] v3y,
    input  logic               tri_valid,
    output logic               tri_ready,
    output logic [COORD_W-1:0] p1x,
    output logic [COORD_W-1:0] p1y,
    output logic [COORD_W-1:0] p2x,
    output logic [COORD_W-1:0] p2y,
    output logic [COORD_W-1:0] p3x,
    output logic [COORD_W-1:0] p3y,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               tri_empty
);
    localparam logic signed [COORD_W:0] XLIM = (COORD_W+1)'(SCREEN_W - 1);
    localparam logic signed [COORD_W:0] YLIM = (COORD_W+1)'(SCREEN_H - 1);

    state_t state_q, state_d;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic signed [COORD_W-1:0] xmn, xmx, ymn, ymx;
    logic signed [COORD_W:0] xmn_e, xmx_e, ymn_e, ymx_e, xlo, xhi, ylo, yhi;
    logic empty, accept, hs;

    minmax3 u_mmx (.a(p1x), .b(p2x), .c(p3x), .mn(xmn), .mx(xmx));
    minmax3 u_mmy (.a(p1y), .b(p2y), .c(p3y), .mn(ymn), .mx(ymx));

    // Widen by one bit so the clamp compares stay signed across the screen limit
    assign xmn_e = {xmn[COORD_W-1], xmn};
    assign xmx_e = {xmx[COORD_W-1], xmx};
    assign ymn_e = {ymn[COORD_W-1], ymn};
    assign ymx_e = {ymx[COORD_W-1], ymx};

    always_comb begin
        xlo = xmn_e[COORD_W] ? '0 : xmn_e;
        xhi = (xmx_e > XLIM) ? XLIM : xmx_e;
        ylo = ymn_e[COORD_W] ? '0 : ymn_e;
        yhi = (ymx_e > YLIM) ? YLIM : ymx_e;
        empty = (xlo > xhi) || (ylo > yhi);
        tri_ready = state_q == IDLE;
        pix_valid = state_q == SCAN;
        pix_last = pix_valid && px == xmax && py == ymax;
        accept = tri_ready && tri_valid;
        hs = pix_valid && pix_ready;
        state_d = state_q;
        case (state_q)
            IDLE: state_d = accept ? BBOX : IDLE;
            BBOX: state_d = empty ? IDLE : SCAN;
            SCAN: state_d = (hs && pix_last) ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {p1x, p1y, p2x, p2y, p3x, p3y} <= '0;
            {xmin, xmax, ymin, ymax} <= '0;
            px <= '0;
            py <= '0;
            tri_empty <= 1'b0;
        end else begin
            tri_empty <= state_q == BBOX && empty;
            if (accept) {p1x, p1y, p2x, p2y, p3x, p3y} <= {v1x, v1y, v2x, v2y, v3x, v3y};
            if (state_q == BBOX && !empty) begin
                xmin <= xlo[COORD_W-1:0];
                xmax <= xhi[COORD_W-1:0];
                ymin <= ylo[COORD_W-1:0];
                ymax <= yhi[COORD_W-1:0];
                px <= xlo[COORD_W-1:0];
                py <= ylo[COORD_W-1:0];
            end else if (hs) begin
                // After the final pixel the counters park back at the box origin
                px <= (px == xmax) ? xmin : px + COORD_W'(1);
                py <= pix_last ? ymin : (px == xmax) ? py + COORD_W'(1) : py;
            end
        end
    end
endmodule

// File: tb/tb_triangle_scan.sv
// tb_triangle_scan: directed and random triangles checked against a bounding-box pixel list model
module tb_triangle_scan;
    logic clk = 1'b0;
    logic rst;
    logic [11:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic tri_valid, tri_ready;
    logic [11:0] p1x, p1y, p2x, p2y, p3x, p3y, px, py;
    logic pix_valid, pix_ready, pix_last, tri_empty;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    triangle_scan dut (
        .clk(clk), .rst(rst),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .px(px), .py(py), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .tri_empty(tri_empty)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int l);
        return (x << 13) | (y << 1) | l;
    endfunction

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    // mode 0: always ready, 1: random back-pressure, 2: 3-cycle stall at (sx,sy)
    task automatic run_tri(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input int mode,
                           input int sx, input int sy, input int abort_n);
        int xl, xh, yl, yh, i, cyc, st;
        int q[$];
        bit pr;
        xl = imax(imin(imin(x1, x2), x3), 0);
        xh = imin(imax(imax(x1, x2), x3), 639);
        yl = imax(imin(imin(y1, y2), y3), 0);
        yh = imin(imax(imax(y1, y2), y3), 479);
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                q.push_back(pk(x, y, int'(x == xh && y == yh)));
        cyc = 0;
        while (!tri_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_wait", tri_ready, 1);
        v1x = 12'(x1); v1y = 12'(y1); v2x = 12'(x2); v2y = 12'(y2); v3x = 12'(x3); v3y = 12'(y3);
        tri_valid = 1'b1;
        pix_ready = 1'b0;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        v1x = 12'($urandom()); v1y = 12'($urandom()); v2x = 12'($urandom());
        v2y = 12'($urandom()); v3x = 12'($urandom()); v3y = 12'($urandom());
        check("bbox_valid", pix_valid, 0);
        check("bbox_ready", tri_ready, 0);
        check("bbox_empty", tri_empty, 0);
        check("p1x", int'($signed(p1x)), x1);
        check("p1y", int'($signed(p1y)), y1);
        check("p2x", int'($signed(p2x)), x2);
        check("p2y", int'($signed(p2y)), y2);
        check("p3x", int'($signed(p3x)), x3);
        check("p3y", int'($signed(p3y)), y3);
        @(posedge clk); #1;
        if (q.size() == 0) begin
            check("empty_pulse", tri_empty, 1);
            check("empty_ready", tri_ready, 1);
            check("empty_valid", pix_valid, 0);
            @(posedge clk); #1;
            check("empty_once", tri_empty, 0);
            check("empty_valid2", pix_valid, 0);
            return;
        end
        check("first_valid", pix_valid, 1);
        i = 0;
        cyc = 0;
        st = 0;
        while (i < q.size() && cyc < 20000) begin
            check("pix_valid", pix_valid, 1);
            check("pix", pk(px, py, pix_last), q[i]);
            check("p1x_hold", int'($signed(p1x)), x1);
            pr = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 2 && (q[i] >> 1) == (pk(sx, sy, 0) >> 1) && st < 3) begin
                pr = 1'b0;
                st++;
            end
            pix_ready = pr;
            @(posedge clk); #1;
            cyc++;
            if (pr) i++;
            if (abort_n >= 0 && i == abort_n) begin
                rst = 1'b1;
                pix_ready = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                pix_ready = 1'b0;
                check("abort_valid", pix_valid, 0);
                check("abort_ready", tri_ready, 1);
                check("abort_empty", tri_empty, 0);
                check("abort_px", px, 0);
                check("abort_p1x", p1x, 0);
                @(posedge clk); #1;
                check("abort_valid2", pix_valid, 0);
                return;
            end
        end
        check("scan_timeout", int'(cyc < 20000), 1);
        pix_ready = 1'b0;
        check("done_valid", pix_valid, 0);
        check("done_ready", tri_ready, 1);
        check("done_empty", tri_empty, 0);
    endtask

    initial begin
        rst = 1'b1;
        tri_valid = 1'b0;
        pix_ready = 1'b0;
        {v1x, v1y, v2x, v2y, v3x, v3y} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", tri_ready, 1);
        check("rst_valid", pix_valid, 0);
        check("rst_last", pix_last, 0);
        check("rst_empty", tri_empty, 0);
        check("rst_px", px, 0);
        check("rst_py", py, 0);
        check("rst_p3y", p3y, 0);
        run_tri(-10, -2, 4, 5, 2, -4, 0, 0, 0, -1);
        run_tri(22, -1, -1, 6, 20, 15, 0, 0, 0, -1);
        run_tri(-17, -4, -5, -15, -43, -20, 0, 0, 0, -1);
        run_tri(-10, -2, 4, 5, 2, -4, 2, 2, 1, -1);
        run_tri(22, -1, -1, 6, 20, 15, 0, 0, 0, 10);
        run_tri(-10, -2, 4, 5, 2, -4, 0, 0, 0, -1);
        run_tri(7, 7, 7, 7, 7, 7, 0, 0, 0, -1);
        run_tri(630, 470, 700, 500, 650, 475, 1, 0, 0, -1);
        run_tri(700, 10, 800, 20, 650, 5, 0, 0, 0, -1);
        run_tri(3, 2, 9, 2, 15, 2, 1, 0, 0, -1);
        for (int t = 0; t < 25; t++) begin
            int cx, cy;
            cx = int'($urandom_range(0, 700)) - 30;
            cy = int'($urandom_range(0, 540)) - 30;
            run_tri(cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                    cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                    cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                    1, 0, 0, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/triangle_scan.md
TRIANGLE_SCAN -- requirements
Module: triangle_scan

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal pixel count (x range 0..SCREEN_W-1).
REQ-002 SHALL have parameter SCREEN_H, default 480, vertical pixel count (y range 0..SCREEN_H-1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports v1x, v1y, v2x, v2y, v3x, v3y  input  12 each  triangle vertices, signed two's complement.
REQ-006 SHALL have port tri_valid  input  1  vertex set on v* is valid.
REQ-007 SHALL have port tri_ready  output  1  block can accept a triangle.
REQ-008 SHALL have ports p1x, p1y, p2x, p2y, p3x, p3y  output  12 each  latched vertices, held for the whole scan, for the downstream point-in-triangle test.
REQ-009 SHALL have ports px, py  output  12 each  current candidate pixel, unsigned, within screen.
REQ-010 SHALL have port pix_valid  output  1  px/py is valid.
REQ-011 SHALL have port pix_ready  input  1  downstream accepts px/py.
REQ-012 SHALL have port pix_last  output  1  qualifies the final pixel of the current triangle.
REQ-013 SHALL have port tri_empty  output  1  one-cycle pulse: accepted triangle produced no pixels.

Function
REQ-014 SHALL implement FSM states IDLE, BBOX, SCAN.
REQ-015 SHALL drive tri_ready=1 only in IDLE; accept on tri_valid&&tri_ready, latch v* into p* on that edge, go to BBOX.
REQ-016 BBOX SHALL last exactly one cycle: register xmin/xmax/ymin/ymax = signed min/max of the three latched vertices.
REQ-017 BBOX SHALL clamp: xmin=max(xmin,0), xmax=min(xmax,SCREEN_W-1), ymin=max(ymin,0), ymax=min(ymax,SCREEN_H-1), compared as signed 13-bit.
REQ-018 If clamped xmin>xmax or ymin>ymax, BBOX SHALL pulse tri_empty for one cycle and return to IDLE, emitting no pixels.
REQ-019 Otherwise BBOX SHALL go to SCAN with px=xmin, py=ymin, pix_valid=1; first pixel two cycles after accept.
REQ-020 SCAN SHALL emit pixels row-major (x fastest), one per pix_valid&&pix_ready handshake, no gaps when pix_ready is held high.
REQ-021 On a handshake with px==xmax SCAN SHALL wrap px to xmin and increment py; otherwise increment px.
REQ-022 pix_last SHALL be 1 exactly when px==xmax and py==ymax in SCAN; a handshake on it SHALL return to IDLE with pix_valid=0 the next cycle.
REQ-023 While pix_valid=1 and pix_ready=0, px, py, pix_last and p* SHALL hold stable.
REQ-024 p* SHALL change only on triangle accept; new vertices on v* during BBOX/SCAN SHALL be ignored.
REQ-025 Degenerate triangles (collinear or coincident vertices) SHALL be scanned over their bounding box without special casing.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, tri_ready=1 next cycle, pix_valid=0, pix_last=0, tri_empty=0, px=py=0, p*=0, bbox registers=0.
REQ-027 Reset asserted mid-BBOX or mid-SCAN SHALL abort the triangle with no further pixels and no tri_empty pulse.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 A shared package SHALL hold COORD_W=12, the FSM state enum, and SCREEN_W/SCREEN_H defaults.
REQ-030 One sub-module minmax3 (combinational signed min and max of three 12-bit values) SHALL be instantiated twice, for x and y.

Verification
REQ-031 Vertices (-10,-2),(4,5),(2,-4), pix_ready=1 -> 30 pixels, first (0,0), last (4,5) with pix_last=1, first pixel 2 cycles after accept.
REQ-032 Vertices (22,-1),(-1,6),(20,15) -> 368 pixels over x 0..22, y 0..15; row wrap (22,0)->(0,1) observed.
REQ-033 Vertices (-17,-4),(-5,-15),(-43,-20) -> tri_empty pulses once, pix_valid stays 0, tri_ready back to 1 two cycles after accept.
REQ-034 Same as REQ-031 with pix_ready low 3 cycles at pixel (2,1) -> px/py/pix_last stable; total count still 30, no duplicates.
REQ-035 rst pulsed after 10th pixel of REQ-032 -> pix_valid=0 next cycle, tri_ready=1, next triangle scans correctly.
REQ-036 Vertices (7,7) x3 -> exactly one pixel (7,7) with pix_last=1.
